// File: rtl/lisa_pkg.sv
// lisa_pkg: shared loader constants (sync marker, error codes, FSM states)
package lisa_pkg;
    localparam logic [7:0] LISA_LDR_SYNC_BYTE = 8'hA5;
    localparam logic [1:0] LISA_LDR_ERR_NONE   = 2'd0;
    localparam logic [1:0] LISA_LDR_ERR_BOUNDS = 2'd1;
    localparam logic [1:0] LISA_LDR_ERR_CSUM   = 2'd2;
    localparam logic [1:0] LISA_LDR_ERR_ABORT  = 2'd3;
    typedef enum logic [2:0] {
        LISA_LDR_ST_IDLE,
        LISA_LDR_ST_LEN_LO,
        LISA_LDR_ST_LEN_HI,
        LISA_LDR_ST_ADDR_LO,
        LISA_LDR_ST_ADDR_HI,
        LISA_LDR_ST_DATA,
        LISA_LDR_ST_CSUM
    } lisa_ldr_st_t;
endpackage

// File: rtl/lisa_imem_loader.sv
// lisa_imem_loader: framed byte-stream loader driving the imem load port, holds the core until a good image lands
module lisa_imem_loader
    import lisa_pkg::*;
#(
    parameter int         MEM_BYTES = 512,
    parameter logic [7:0] SYNC_BYTE = LISA_LDR_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        abort,
    output logic        load_we,
    output logic [15:0] load_addr,
    output logic [7:0]  load_data,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);
    localparam logic [16:0] MEM_LIM = 17'(MEM_BYTES);

    lisa_ldr_st_t state, nxt;
    logic [15:0] len, len_n, base, base_n, idx, idx_n, addr_n;
    logic [7:0]  csum, csum_n, data_n;
    logic        we_n, done_n, hold_n;
    logic [1:0]  err_n;
    logic [16:0] frame_end;

    assign s_ready   = 1'b1;
    assign busy      = state != LISA_LDR_ST_IDLE;
    // 17-bit so a huge len cannot wrap past the bound
    assign frame_end = {1'b0, s_data, base[7:0]} + {1'b0, len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LISA_LDR_ST_IDLE;
            len       <= '0;
            base      <= '0;
            idx       <= '0;
            csum      <= '0;
            load_we   <= 1'b0;
            load_addr <= '0;
            load_data <= '0;
            done      <= 1'b0;
            err_code  <= LISA_LDR_ERR_NONE;
            core_hold <= 1'b1;
        end else begin
            state     <= nxt;
            len       <= len_n;
            base      <= base_n;
            idx       <= idx_n;
            csum      <= csum_n;
            load_we   <= we_n;
            load_addr <= addr_n;
            load_data <= data_n;
            done      <= done_n;
            err_code  <= err_n;
            core_hold <= hold_n;
        end
    end

    always_comb begin
        nxt    = state;
        len_n  = len;
        base_n = base;
        idx_n  = idx;
        csum_n = csum;
        we_n   = 1'b0;
        addr_n = load_addr;
        data_n = load_data;
        done_n = 1'b0;
        err_n  = err_code;
        hold_n = core_hold;
        if (abort && state != LISA_LDR_ST_IDLE) begin
            nxt    = LISA_LDR_ST_IDLE;
            err_n  = LISA_LDR_ERR_ABORT;
            hold_n = 1'b1;
        end else if (s_valid) begin
            case (state)
                LISA_LDR_ST_IDLE: begin
                    if (s_data == SYNC_BYTE) begin
                        nxt    = LISA_LDR_ST_LEN_LO;
                        csum_n = '0;
                        err_n  = LISA_LDR_ERR_NONE;
                        hold_n = 1'b1;
                    end
                end
                LISA_LDR_ST_LEN_LO: begin
                    len_n[7:0] = s_data;
                    csum_n     = csum ^ s_data;
                    nxt        = LISA_LDR_ST_LEN_HI;
                end
                LISA_LDR_ST_LEN_HI: begin
                    len_n[15:8] = s_data;
                    csum_n      = csum ^ s_data;
                    nxt         = LISA_LDR_ST_ADDR_LO;
                end
                LISA_LDR_ST_ADDR_LO: begin
                    base_n[7:0] = s_data;
                    csum_n      = csum ^ s_data;
                    nxt         = LISA_LDR_ST_ADDR_HI;
                end
                LISA_LDR_ST_ADDR_HI: begin
                    base_n[15:8] = s_data;
                    csum_n       = csum ^ s_data;
                    idx_n        = '0;
                    if (frame_end > MEM_LIM) begin
                        err_n = LISA_LDR_ERR_BOUNDS;
                        nxt   = LISA_LDR_ST_IDLE;
                    end else begin
                        nxt = (len == '0) ? LISA_LDR_ST_CSUM : LISA_LDR_ST_DATA;
                    end
                end
                LISA_LDR_ST_DATA: begin
                    we_n   = 1'b1;
                    addr_n = base + idx;
                    data_n = s_data;
                    csum_n = csum ^ s_data;
                    idx_n  = idx + 16'd1;
                    nxt    = (idx_n == len) ? LISA_LDR_ST_CSUM : LISA_LDR_ST_DATA;
                end
                LISA_LDR_ST_CSUM: begin
                    done_n = s_data == csum;
                    hold_n = s_data != csum;
                    err_n  = (s_data == csum) ? LISA_LDR_ERR_NONE : LISA_LDR_ERR_CSUM;
                    nxt    = LISA_LDR_ST_IDLE;
                end
                default: nxt = LISA_LDR_ST_IDLE;
            endcase
        end
    end
endmodule
